score_bcd_sequencer: RTL

Multi-cycle controller that turns the binary game score into three BCD digits for the HEX0–HEX2 seven-segment decoders. It accepts score updates from the game FSM over a valid/ready handshake and runs an iterative shift-and-add-3 conversion, one bit per cycle. It then commits the digits and drives per-digit enables for leading-zero blanking and game-over blinking. It sits between the game logic and the per-digit 7-segment decoders.

---
 rtl/score_disp_pkg.sv | 26 ++
 rtl/bcd_add3.sv | 11 +
 rtl/score_bcd_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/score_disp_pkg.sv
// Shared types and constants for the score-to-BCD display sequencer.
package score_disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    COMMIT
  } state_t;

  localparam int BCD_DIGITS  = 3;
  localparam int DIGIT_W     = 4;
  localparam int BCD_W       = BCD_DIGITS * DIGIT_W;
  localparam int ADD3_THRESH = 5;

  // Per-digit enables {hund, tens, ones}; ones is always lit so a score of 0 shows "0".
  function automatic logic [2:0] lz_mask(input logic [BCD_W-1:0] bcd, input bit blank);
    logic hund_nz;
    logic tens_nz;
    hund_nz = |bcd[11:8];
    tens_nz = |bcd[7:4];
    if (!blank) return 3'b111;
    return {hund_nz, hund_nz | tens_nz, 1'b1};
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// One double-dabble correction cell: nibbles of 5 or more get +3 before the shift.
module bcd_add3
  import score_disp_pkg::*;
(
  input  logic [DIGIT_W-1:0] nibble,
  output logic [DIGIT_W-1:0] adj
);

  assign adj = (nibble >= DIGIT_W'(ADD3_THRESH)) ? nibble + DIGIT_W'(3) : nibble;

endmodule

// File: rtl/score_bcd_sequencer.sv
// Iterative binary-to-BCD converter for the score display, with leading-zero
// blanking and a game-over blink applied to the registered digit enables.
module score_bcd_sequencer
  import score_disp_pkg::*;
#(
  parameter int SCORE_W   = 8,
  parameter int WRAP_AT   = 251,
  parameter int BLINK_DIV = 25000000,
  parameter int BLANK_LZ  = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [SCORE_W-1:0] score_in,
  input  logic               score_valid,
  output logic               score_ready,
  input  logic               game_over,
  output logic [BCD_W-1:0]   bcd_out,
  output logic [2:0]         digit_en,
  output logic               wrapped,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W   = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [2:0] MASK_RST = (BLANK_LZ != 0) ? 3'b001 : 3'b111;

  // Three BCD digits hold at most 999; wider scores could overflow silently.
  if (SCORE_W > 9 || SCORE_W < 1) begin : g_bad_width
    $error("score_bcd_sequencer: SCORE_W must be 1..9");
  end

  state_t               state;
  state_t               state_next;
  logic [SCORE_W-1:0]   bin_sr;
  logic [BCD_W-1:0]     bcd_sr;
  logic [BCD_W-1:0]     bcd_adj;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 wrap_pend;
  logic [2:0]           mask;
  logic [2:0]           mask_d;
  logic [BLINK_W-1:0]   blink_cnt;
  logic [BLINK_W-1:0]   blink_cnt_d;
  logic                 blink_on;
  logic                 blink_on_d;
  logic                 accept;
  logic                 wrap_hit;

  assign score_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign accept      = score_valid & score_ready;
  assign wrap_hit    = 32'(score_in) >= 32'(WRAP_AT);

  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .nibble (bcd_sr[i*DIGIT_W +: DIGIT_W]),
      .adj    (bcd_adj[i*DIGIT_W +: DIGIT_W])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   if (bit_cnt == '0) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Mask follows each commit; blink phase runs independently of commits.
  always_comb begin
    mask_d      = mask;
    blink_cnt_d = blink_cnt;
    blink_on_d  = blink_on;
    if (state == COMMIT) mask_d = lz_mask(bcd_sr, BLANK_LZ != 0);
    if (!game_over) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on;
    end else begin
      blink_cnt_d = blink_cnt + BLINK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bin_sr    <= '0;
      bcd_sr    <= '0;
      bit_cnt   <= '0;
      wrap_pend <= 1'b0;
      bcd_out   <= '0;
      wrapped   <= 1'b0;
      done      <= 1'b0;
      mask      <= MASK_RST;
      digit_en  <= MASK_RST;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      done      <= 1'b0;
      mask      <= mask_d;
      blink_cnt <= blink_cnt_d;
      blink_on  <= blink_on_d;
      digit_en  <= blink_on_d ? mask_d : 3'b000;
      unique case (state)
        IDLE: begin
          if (accept) begin
            bin_sr    <= wrap_hit ? '0 : score_in;
            wrap_pend <= wrap_hit;
          end
        end
        LOAD: begin
          bcd_sr  <= '0;
          bit_cnt <= CNT_W'(SCORE_W - 1);
        end
        SHIFT: begin
          // The hundreds carry-out is always 0 for SCORE_W <= 9, so it is dropped.
          bcd_sr  <= BCD_W'({bcd_adj, bin_sr[SCORE_W-1]});
          bin_sr  <= bin_sr << 1;
          bit_cnt <= bit_cnt - CNT_W'(1);
        end
        COMMIT: begin
          bcd_out <= bcd_sr;
          wrapped <= wrap_pend;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
